// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between requesters and rr_arbiter.
// master = requester side, slave = arbiter side.
interface rr_arbiter_if #(
  parameter int N = 8,
  parameter int W = 3
);
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] grant;
  logic [W-1:0] grant_id;
  logic         grant_valid;
  logic         timeout;

  modport master (
    output req, done,
    input  grant, grant_id, grant_valid, timeout
  );

  modport slave (
    input  req, done,
    output grant, grant_id, grant_valid, timeout
  );
endinterface

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter with registered, held grants.
// Optional forced release after MAX_HOLD cycles: define RR_ARB_TIMEOUT_EN.
module rr_arbiter #(
  parameter int N        = 8,
  parameter int W        = 3,
  parameter int MAX_HOLD = 16
) (
  input logic         clk,
  input logic         reset,
  rr_arbiter_if.slave bus
);

  if (N < 2 || (1 << W) < N || MAX_HOLD < 1) begin : g_bad
    $error("rr_arbiter: illegal parameters");
  end

  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t       state, state_n;
  logic [N-1:0] grant, grant_n;
  logic [W-1:0] id, id_n;
  logic [W-1:0] last, last_n;
  logic [W-1:0] pick;
  logic         found;
  logic         drop;
  int           idx;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] cnt, cnt_n;
  logic          tmo, tmo_n;
  logic          expire;
  assign expire = (cnt == CW'(MAX_HOLD - 1));
`endif

  // Scan starts just past the previous holder so it ranks last.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = W'(idx);
      end
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    id_n    = id;
    last_n  = last;
    drop    = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
    cnt_n   = cnt;
    tmo_n   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = BUSY;
          grant_n = ONE << pick;
          id_n    = pick;
`ifdef RR_ARB_TIMEOUT_EN
          cnt_n   = '0;
`endif
        end
      end
      BUSY: begin
        drop = bus.done || !bus.req[id];
`ifdef RR_ARB_TIMEOUT_EN
        cnt_n = cnt + 1'b1;
        if (!drop && expire) begin
          drop  = 1'b1;
          tmo_n = 1'b1;
        end
`endif
        if (drop) begin
          state_n = IDLE;
          grant_n = '0;
          id_n    = '0;
          last_n  = id;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      id    <= '0;
      last  <= W'(N - 1);
`ifdef RR_ARB_TIMEOUT_EN
      cnt   <= '0;
      tmo   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      grant <= grant_n;
      id    <= id_n;
      last  <= last_n;
`ifdef RR_ARB_TIMEOUT_EN
      cnt   <= cnt_n;
      tmo   <= tmo_n;
`endif
    end
  end

  assign bus.grant       = grant;
  assign bus.grant_id    = id;
  assign bus.grant_valid = |grant;
`ifdef RR_ARB_TIMEOUT_EN
  assign bus.timeout     = tmo;
`else
  assign bus.timeout     = 1'b0;
`endif

endmodule
